opb_register_simulink2ppc: RTL and testbench
============================================

OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01000F00, first byte of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h01000FFF, last byte of the slave window.
REQ-003 SHALL have parameters C_OPB_AWIDTH (32, address width), C_OPB_DWIDTH (32, data width) and C_FAMILY ("virtex5", target device).
REQ-004 SHALL have port OPB_Clk, input, 1, the single clock for all logic; no other clock exists.
REQ-005 SHALL have port OPB_Rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have OPB slave inputs: OPB_ABus [0:31], OPB_BE [0:3], OPB_DBus [0:31], OPB_RNW 1, OPB_select 1, OPB_seqAddr 1.
REQ-007 SHALL have OPB slave outputs: Sl_DBus [0:31], Sl_xferAck 1, Sl_errAck 1, Sl_retry 1, Sl_toutSup 1.
REQ-008 SHALL have user_data_in, input, [31:0], value produced by fabric.
REQ-009 SHALL have user_data_valid, input, 1, single-cycle capture strobe for user_data_in.

Function
REQ-010 SHALL map offsets: 0x00 DATA (RO), 0x04 STATUS (R/W1C), 0x08-end reserved (read 0, writes ignored).
REQ-011 SHALL lay out STATUS as bit31 NEW, bit30 OVERRUN, bits[15:0] CAPTURE_COUNT, all other bits 0.
REQ-012 SHALL drive bus bit Sl_DBus[i] from register bit [31-i].
REQ-013 SHALL decode a hit when OPB_select=1, OPB_ABus within [C_BASEADDR,C_HIGHADDR] and Sl_xferAck=0.
REQ-014 SHALL assert Sl_xferAck for exactly one cycle, registered, in the cycle after a hit: latency 1.
REQ-015 SHALL drive Sl_DBus with the read data only in the ack cycle of a read and all-zero otherwise.
REQ-016 SHALL tie Sl_errAck, Sl_retry and Sl_toutSup to 0 and ignore OPB_seqAddr and OPB_BE for reads.
REQ-017 SHALL, on user_data_valid=1, latch user_data_in into DATA, set NEW, and increment CAPTURE_COUNT modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-018 SHALL set OVERRUN when user_data_valid=1 while NEW=1 and NEW is not being cleared in that cycle.
REQ-019 SHALL clear NEW on the ack cycle of a DATA read.
REQ-020 SHALL clear OVERRUN on a STATUS write with OPB_DBus bit (bus index 1) =1 and OPB_BE[0]=1; other written bits have no effect.
REQ-021 SHALL, when capture and DATA-read ack coincide, return the pre-capture DATA and leave NEW=1 (capture wins); OVERRUN unchanged.
REQ-022 SHALL, when capture and OVERRUN-clear coincide with NEW=1, leave OVERRUN=1 (set wins).
REQ-023 SHALL sample read data (DATA/STATUS) in the hit cycle, so the returned value is coherent with the ack.
REQ-024 SHALL accept a new hit no earlier than the cycle after an ack (maximum one transfer per two cycles).

Reset
REQ-025 SHALL, while OPB_Rst_n=0, hold Sl_xferAck=0, Sl_DBus=0, DATA=0, NEW=0, OVERRUN=0, CAPTURE_COUNT=0, independent of OPB_Clk.
REQ-026 SHALL abort any pending ack on reset assertion mid-transfer; no ack is issued after release for that transfer.
REQ-027 SHALL ignore user_data_valid during reset.

Structure
REQ-028 SHALL place offset constants (DATA=0x00, STATUS=0x04) and STATUS bit positions in the shared OPB register package.
REQ-029 SHALL contain one sub-module, opb_slave_decode, holding address decode and the ack/one-shot logic; capture registers stay in the top.

Verification
REQ-030 SHALL test: reset, then read 0x04 -> Sl_xferAck one cycle after select, Sl_DBus=0x00000000.
REQ-031 SHALL test: valid with 0xDEADBEEF, read 0x00 then 0x04 -> 0xDEADBEEF, then STATUS=0x00000001 (NEW cleared, count 1).
REQ-032 SHALL test: two valids (0x11, 0x22) without read -> DATA=0x22, STATUS=0xC0000002.
REQ-033 SHALL test: write 0x40000000 to 0x04 after overrun -> OVERRUN cleared, NEW and count kept.
REQ-034 SHALL test: valid 0x55 in the same cycle as DATA read ack with old DATA 0x33 -> read returns 0x33, NEW=1.
REQ-035 SHALL test: 65536 valids from reset -> CAPTURE_COUNT=0x0000; assert OPB_Rst_n=0 mid-read -> no ack, all outputs 0.

Source files
------------

// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared OPB register definitions: register offsets, STATUS bit positions and
// the decoded-transfer payload passed from the slave decoder to the register file.
package opb_register_simulink2ppc_pkg;

  localparam int unsigned REG_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OFF_W = 32;

  localparam logic [OFF_W-1:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [OFF_W-1:0] OFF_STATUS = 32'h0000_0004;

  localparam int unsigned STATUS_NEW_BIT = 31;
  localparam int unsigned STATUS_OVR_BIT = 30;

  typedef enum logic [1:0] {
    SEL_DATA   = 2'd0,
    SEL_STATUS = 2'd1,
    SEL_RSVD   = 2'd2
  } reg_sel_e;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_e;

  typedef struct packed {
    logic     valid;
    logic     rnw;
    reg_sel_e sel;
  } xfer_t;

  // Assemble the STATUS word; unlisted bits read as zero.
  function automatic logic [REG_W-1:0] status_word(input logic             new_f,
                                                   input logic             ovr,
                                                   input logic [CNT_W-1:0] cnt);
    logic [REG_W-1:0] w;
    w                 = '0;
    w[STATUS_NEW_BIT] = new_f;
    w[STATUS_OVR_BIT] = ovr;
    w[CNT_W-1:0]      = cnt;
    return w;
  endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// OPB slave window decode and single-cycle acknowledge generator.
// A hit is blocked while the ack is high, giving at most one transfer per two cycles.
module opb_slave_decode
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter int unsigned  AW       = 32,
  parameter logic [AW-1:0] BASEADDR = '0,
  parameter logic [AW-1:0] HIGHADDR = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          select,
  input  logic [AW-1:0] abus,
  input  logic          rnw,
  output xfer_t         hit_c,
  output logic          xfer_ack,
  output xfer_t         ack_xfer
);

  ack_state_e    state_q, state_d;
  xfer_t         ack_xfer_q;
  logic          in_range_c;
  logic [AW-1:0] offset_c;
  logic [AW-1:0] word_off_c;

  assign in_range_c = (abus >= BASEADDR) && (abus <= HIGHADDR);
  assign offset_c   = abus - BASEADDR;
  assign word_off_c = {offset_c[AW-1:2], 2'b00};

  // Combinational hit and register select for the current address phase.
  always_comb begin
    hit_c       = '0;
    hit_c.valid = select && in_range_c && (state_q == ACK_IDLE);
    hit_c.rnw   = rnw;
    if (word_off_c == AW'(OFF_DATA)) begin
      hit_c.sel = SEL_DATA;
    end else if (word_off_c == AW'(OFF_STATUS)) begin
      hit_c.sel = SEL_STATUS;
    end else begin
      hit_c.sel = SEL_RSVD;
    end
  end

  // One-shot acknowledge: BUSY lasts exactly the cycle after a hit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACK_IDLE: if (hit_c.valid) state_d = ACK_BUSY;
      ACK_BUSY: state_d = ACK_IDLE;
      default:  state_d = ACK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACK_IDLE;
      ack_xfer_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_xfer_q <= hit_c.valid ? hit_c : '0;
    end
  end

  assign xfer_ack = (state_q == ACK_BUSY);
  assign ack_xfer = ack_xfer_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC OPB register: captures user_data_in on a strobe and exposes
// it as DATA with a NEW/OVERRUN/count STATUS word.
module opb_register_simulink2ppc
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0F00,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_0FFF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  // No device-specific primitives are used; the family only exists for tool flows.
  localparam bit FAMILY_V5 = (C_FAMILY == "virtex5");

  xfer_t            hit_c;
  xfer_t            ack_xfer;
  logic             xfer_ack;

  logic [REG_W-1:0] data_q;
  logic             new_q;
  logic             ovr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REG_W-1:0] sl_dbus_q;

  logic             new_clr_c;
  logic             ovr_clr_c;
  logic             ovr_set_c;
  logic [REG_W-1:0] rd_mux_c;
  logic             unused_ok;

  opb_slave_decode #(
    .AW       (C_OPB_AWIDTH),
    .BASEADDR (C_OPB_AWIDTH'(C_BASEADDR)),
    .HIGHADDR (C_OPB_AWIDTH'(C_HIGHADDR))
  ) u_decode (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .select   (OPB_select),
    .abus     (OPB_ABus),
    .rnw      (OPB_RNW),
    .hit_c    (hit_c),
    .xfer_ack (xfer_ack),
    .ack_xfer (ack_xfer)
  );

  // Bus bit 1 is register bit 30 (OVERRUN); byte lane 0 carries it.
  assign new_clr_c = ack_xfer.valid && ack_xfer.rnw && (ack_xfer.sel == SEL_DATA);
  assign ovr_clr_c = hit_c.valid && !hit_c.rnw && (hit_c.sel == SEL_STATUS) &&
                     OPB_BE[0] && OPB_DBus[1];
  assign ovr_set_c = user_data_valid && new_q && !new_clr_c;

  always_comb begin
    rd_mux_c = '0;
    unique case (hit_c.sel)
      SEL_DATA:   rd_mux_c = data_q;
      SEL_STATUS: rd_mux_c = status_word(new_q, ovr_q, cnt_q);
      default:    rd_mux_c = '0;
    endcase
  end

  // Capture path; a fresh capture outranks NEW-clear and OVERRUN-clear.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q <= '0;
      new_q  <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (user_data_valid) begin
        data_q <= user_data_in;
        new_q  <= 1'b1;
        cnt_q  <= cnt_q + CNT_W'(1);
      end else if (new_clr_c) begin
        new_q  <= 1'b0;
      end
      if (ovr_set_c) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr_c) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Read data is sampled at the hit and is non-zero only during the ack cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      sl_dbus_q <= '0;
    end else begin
      sl_dbus_q <= (hit_c.valid && hit_c.rnw) ? rd_mux_c : '0;
    end
  end

  assign Sl_DBus    = C_OPB_DWIDTH'(sl_dbus_q);
  assign Sl_xferAck = xfer_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, OPB_BE[1:3], OPB_DBus[0],
                       OPB_DBus[2:C_OPB_DWIDTH-1], FAMILY_V5};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc with hand-computed expectations.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0100_0F00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  opb_register_simulink2ppc dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_ABus        (OPB_ABus),
    .OPB_BE          (OPB_BE),
    .OPB_DBus        (OPB_DBus),
    .OPB_RNW         (OPB_RNW),
    .OPB_select      (OPB_select),
    .OPB_seqAddr     (OPB_seqAddr),
    .Sl_DBus         (Sl_DBus),
    .Sl_xferAck      (Sl_xferAck),
    .Sl_errAck       (Sl_errAck),
    .Sl_retry        (Sl_retry),
    .Sl_toutSup      (Sl_toutSup),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup};
  endfunction

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    OPB_ABus = addr; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("rd_ack_rise", 32'(Sl_xferAck), 32'd1);
    data = Sl_DBus;
    OPB_select = 1'b0; OPB_ABus = '0;
    @(posedge clk); #1;
    check("rd_ack_fall", 32'(Sl_xferAck), 32'd0);
    check("rd_dbus_idle", Sl_DBus, 32'd0);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    OPB_ABus = addr; OPB_RNW = 1'b0; OPB_BE = be; OPB_DBus = wdata; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("wr_ack_rise", 32'(Sl_xferAck), 32'd1);
    check("wr_dbus_zero", Sl_DBus, 32'd0);
    OPB_select = 1'b0; OPB_ABus = '0; OPB_DBus = '0;
    @(posedge clk); #1;
  endtask

  task automatic capture(input logic [31:0] d);
    user_data_in = d; user_data_valid = 1'b1;
    @(posedge clk); #1;
    user_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; OPB_select = 1'b0; user_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [31:0] d;

  initial begin
    rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b1;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_data_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_outs", outs(), 32'd0);
    check("rst_dbus", Sl_DBus, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty STATUS after reset
    bus_read(BASE + 32'h4, d);
    check("rst_status", d, 32'h0000_0000);

    // Single capture, DATA read clears NEW
    capture(32'hDEAD_BEEF);
    bus_read(BASE + 32'h0, d);
    check("data_deadbeef", d, 32'hDEAD_BEEF);
    bus_read(BASE + 32'h4, d);
    check("status_after_read", d, 32'h0000_0001);

    // Two captures without a read -> overrun; BE[0]=0 write ignored; then clear
    do_reset();
    capture(32'h11);
    capture(32'h22);
    bus_read(BASE + 32'h4, d);
    check("status_overrun", d, 32'hC000_0002);
    bus_write(BASE + 32'h4, 32'h4000_0000, 4'b0111);
    bus_read(BASE + 32'h4, d);
    check("status_be0_off", d, 32'hC000_0002);
    bus_write(BASE + 32'h4, 32'h4000_0000, 4'hF);
    bus_read(BASE + 32'h4, d);
    check("status_ovr_clr", d, 32'h8000_0002);
    bus_write(BASE + 32'h0, 32'h1234_5678, 4'hF);
    bus_read(BASE + 32'h0, d);
    check("data_ro", d, 32'h0000_0022);
    bus_read(BASE + 32'h4, d);
    check("status_new_clr", d, 32'h0000_0002);

    // Reserved offsets read zero; out-of-window address never acks
    bus_read(BASE + 32'h8, d);
    check("rsvd_08", d, 32'h0);
    bus_read(BASE + 32'hFC, d);
    check("rsvd_fc", d, 32'h0);
    OPB_ABus = BASE + 32'h100; OPB_RNW = 1'b1; OPB_select = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("oow_no_ack", 32'(Sl_xferAck), 32'd0);
    end
    OPB_select = 1'b0;

    // Capture coincides with DATA-read ack: old data returned, NEW stays set
    do_reset();
    capture(32'h33);
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("coinc_ack", 32'(Sl_xferAck), 32'd1);
    d = Sl_DBus;
    OPB_select = 1'b0; user_data_in = 32'h55; user_data_valid = 1'b1;
    @(posedge clk); #1;
    user_data_valid = 1'b0;
    check("coinc_rdata", d, 32'h0000_0033);
    bus_read(BASE + 32'h4, d);
    check("coinc_status", d, 32'h8000_0002);
    bus_read(BASE + 32'h0, d);
    check("coinc_newdata", d, 32'h0000_0055);

    // Capture coincides with OVERRUN clear while NEW=1: set wins
    do_reset();
    capture(32'h1);
    capture(32'h2);
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'h4000_0000;
    OPB_select = 1'b1; user_data_in = 32'h3; user_data_valid = 1'b1;
    @(posedge clk); #1;
    user_data_valid = 1'b0; OPB_select = 1'b0;
    check("setwin_ack", 32'(Sl_xferAck), 32'd1);
    @(posedge clk); #1;
    bus_read(BASE + 32'h4, d);
    check("setwin_status", d, 32'hC000_0003);

    // Capture count wraps at 2^16
    do_reset();
    user_data_in = 32'hA5A5_A5A5; user_data_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1 user_data_valid = 1'b0;
    bus_read(BASE + 32'h4, d);
    check("cnt_ffff", d, 32'hC000_FFFF);
    capture(32'h0);
    bus_read(BASE + 32'h4, d);
    check("cnt_wrap", d, 32'hC000_0000);

    // Reset asserted during the ack cycle clears outputs without a clock edge
    do_reset();
    capture(32'hCAFE_F00D);
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("midrd_ack", 32'(Sl_xferAck), 32'd1);
    check("midrd_data", Sl_DBus, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    check("midrd_rst_outs", outs(), 32'd0);
    check("midrd_rst_dbus", Sl_DBus, 32'd0);
    OPB_select = 1'b0; user_data_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 user_data_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("midrd_no_ack", outs(), 32'd0);
    end
    bus_read(BASE + 32'h4, d);
    check("midrd_status", d, 32'h0);

    // Reset asserted before the hit edge: the pending transfer never acks
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_select = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("pre_hit_rst", outs(), 32'd0);
    OPB_select = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("pre_hit_no_ack", outs(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
